// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronise/deglitch lines, frame capture, E0/F0 prefix folding, FWFT event FIFO.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic [7:0]                      ev_code,
  output logic                            ev_ext,
  output logic                            ev_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0] clk_sync_q, dat_sync_q;
  logic [3:0] clk_cnt_q, dat_cnt_q;
  logic       clk_f_q, dat_f_q, clk_f_prev_q;
  logic       fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // A filtered line flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt_q    <= '0;
      dat_cnt_q    <= '0;
      clk_f_q      <= 1'b1;
      dat_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
    end else begin
      clk_f_prev_q <= clk_f_q;
      if (clk_sync_q[1] == clk_f_q) begin
        clk_cnt_q <= '0;
      end else if (clk_cnt_q == 4'(FILTER_LEN - 1)) begin
        clk_f_q   <= clk_sync_q[1];
        clk_cnt_q <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + 4'd1;
      end
      if (dat_sync_q[1] == dat_f_q) begin
        dat_cnt_q <= '0;
      end else if (dat_cnt_q == 4'(FILTER_LEN - 1)) begin
        dat_f_q   <= dat_sync_q[1];
        dat_cnt_q <= '0;
      end else begin
        dat_cnt_q <= dat_cnt_q + 4'd1;
      end
    end
  end

  assign fall = clk_f_prev_q & ~clk_f_q;

  state_t      state_q;
  logic [2:0]  ptr_q;
  logic [7:0]  byte_q;
  logic [TW-1:0] tmo_q;
  logic        ext_q, brk_q;
  logic        push_q;
  logic [9:0]  push_dat_q;
  logic        frame_err_q;
`ifdef PS2_PARITY_CHECK_EN
  logic        par_q;
  logic        parity_err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      byte_q       <= '0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      push_q       <= 1'b0;
      push_dat_q   <= '0;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
      if (fall || state_q == IDLE) tmo_q <= '0;
      else                         tmo_q <= tmo_q + 1'b1;

      if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            if (!dat_f_q) begin
              state_q <= DATA;
              ptr_q   <= '0;
            end
          end
          DATA: begin
            byte_q[ptr_q] <= dat_f_q;
            if (ptr_q == 3'd7) state_q <= PARITY;
            else               ptr_q   <= ptr_q + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q <= dat_f_q;
`endif
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dat_f_q) begin
              frame_err_q <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            end else if (~^{byte_q, par_q}) begin
              parity_err_q <= 1'b1;
`endif
            end else if (byte_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              push_q     <= 1'b1;
              push_dat_q <= {ext_q, brk_q, byte_q};
              ext_q      <= 1'b0;
              brk_q      <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, push_ok;
  logic [9:0]    head;

  assign pop     = (cnt_q != '0) && ev_ready;
  assign push_ok = push_q && ((cnt_q < CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_q;
  end

  // Head fields are gated so an empty FIFO presents all zeros.
  assign head     = mem_q[rd_ptr_q];
  assign ev_valid = (cnt_q != '0);
  assign ev_code  = ev_valid ? head[7:0] : 8'h00;
  assign ev_break = ev_valid & head[8];
  assign ev_ext   = ev_valid & head[9];
  assign ev_count = cnt_q;
  assign frame_err = frame_err_q;
  assign overflow  = push_q & ~push_ok;
`ifdef PS2_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomised bench for ps2_scan_decoder against a byte-level keyboard-event model.
module tb_ps2_scan_decoder;
  localparam int FL    = 4;
  localparam int TMO   = 2000;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ev_ready = 1'b0;
  logic ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow;
  logic [7:0] ev_code;
  logic [CW-1:0] ev_count;

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_count(ev_count), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0;
  int e_perr = 0, e_ferr = 0, e_ovf = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
      if (ev_valid && ev_ready) got_q.push_back({ev_ext, ev_break, ev_code});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: keyboard protocol rules applied to whole received bytes.
  function automatic void model_frame(logic [7:0] b, bit par_ok, bit stop_ok);
    if (!stop_ok) begin e_ferr++; return; end
`ifdef PS2_PARITY_CHECK_EN
    if (!par_ok) begin e_perr++; return; end
`endif
    if (b == 8'hE0)      m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(bit b, int half, bit glitch, bit pulse_ready);
    ps2_data = b;
    tick(half / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      tick($urandom_range(1, FL - 1));
      ps2_clk = 1'b1;
    end
    tick(half - half / 2);
    ps2_clk = 1'b0;
    if (pulse_ready) begin
      tick(FL + 3);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      tick(half - FL - 4);
    end else begin
      tick(half);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0,
                            int nbits = 11, bit pulse_ready = 0);
    logic [10:0] fr;
    int half;
    half = $urandom_range(16, 24);
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++)
      ps2_bit(fr[i], half, $urandom_range(0, 1) == 1, pulse_ready && (i == 10));
    ps2_data = 1'b1;
    tick(half);
  endtask

  task automatic test_reset;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if ({ev_valid, ev_code, ev_ext, ev_break, ev_count, parity_err, frame_err, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 0",
               {ev_valid, ev_code, ev_ext, ev_break, ev_count, parity_err, frame_err, overflow});
    end
    tick(1);
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int g0, f0, p0, vld_cyc, max_cnt;
    g0 = got_q.size(); f0 = n_ferr; p0 = n_perr; vld_cyc = 0; max_cnt = 0;
    exp_q.delete();
    ev_ready = 1'b1;
    model_frame(8'h1C, 1, 1);
    fork
      send_frame(8'h1C);
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        if (ev_valid) vld_cyc++;
        if (int'(ev_count) > max_cnt) max_cnt = int'(ev_count);
      end
    join
    n_cmp++;
    if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL single_events got %0d want 1", got_q.size() - g0); end
    else begin
      n_cmp++;
      if (got_q[g0] !== exp_q[0]) begin n_err++; $display("FAIL single_event got %h want %h", got_q[g0], exp_q[0]); end
    end
    n_cmp++;
    if (vld_cyc !== 1) begin n_err++; $display("FAIL single_valid_cycles got %0d want 1", vld_cyc); end
    n_cmp++;
    if (max_cnt !== 1 || ev_count !== '0) begin n_err++; $display("FAIL single_count got max %0d end %0d want 1/0", max_cnt, ev_count); end
    n_cmp++;
    if (n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin n_err++; $display("FAIL single_err_pulses got %0d/%0d want 0/0", n_ferr - f0, n_perr - p0); end
    ev_ready = 1'b0;
  endtask

  task automatic test_prefix;
    int g0;
    g0 = got_q.size();
    exp_q.delete();
    ev_ready = 1'b0;
    send_frame(8'hE0); model_frame(8'hE0, 1, 1);
    send_frame(8'hF0); model_frame(8'hF0, 1, 1);
    send_frame(8'h75); model_frame(8'h75, 1, 1);
    tick(10);
    @(negedge clk);
    n_cmp++;
    if (ev_count !== CW'(1)) begin n_err++; $display("FAIL prefix_count got %0d want 1", ev_count); end
    n_cmp++;
    if ({ev_ext, ev_break, ev_code} !== exp_q[0]) begin n_err++; $display("FAIL prefix_head got %h want %h", {ev_ext, ev_break, ev_code}, exp_q[0]); end
    tick(1);
    ev_ready = 1'b1;
    tick(5);
    ev_ready = 1'b0;
    n_cmp++;
    if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL prefix_events got %0d want 1", got_q.size() - g0); end
  endtask

  task automatic test_parity;
    int g0, p0;
    g0 = got_q.size(); p0 = n_perr;
    exp_q.delete(); e_perr = 0;
    ev_ready = 1'b1;
    send_frame(8'h1C, 1);
    model_frame(8'h1C, 0, 1);
    tick(10);
    n_cmp++;
    if (n_perr - p0 !== e_perr) begin n_err++; $display("FAIL parity_pulses got %0d want %0d", n_perr - p0, e_perr); end
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL parity_events got %0d want %0d", got_q.size() - g0, exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[g0 + i] !== exp_q[i]) begin n_err++; $display("FAIL parity_event got %h want %h", got_q[g0 + i], exp_q[i]); end
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_timeout(bit with_f0);
    int g0, f0;
    g0 = got_q.size(); f0 = n_ferr;
    exp_q.delete(); e_ferr = 0;
    ev_ready = 1'b1;
    if (with_f0) begin send_frame(8'hF0); model_frame(8'hF0, 1, 1); end
    send_frame(8'($urandom), 0, 0, 5);
    tick(TMO + 10);
    e_ferr++; m_ext = 0; m_brk = 0;
    send_frame(8'h29); model_frame(8'h29, 1, 1);
    tick(10);
    n_cmp++;
    if (n_ferr - f0 !== e_ferr) begin n_err++; $display("FAIL timeout_frame_err got %0d want %0d (f0=%0d)", n_ferr - f0, e_ferr, with_f0); end
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL timeout_events got %0d want %0d", got_q.size() - g0, exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[g0 + i] !== exp_q[i]) begin n_err++; $display("FAIL timeout_event got %h want %h", got_q[g0 + i], exp_q[i]); end
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_overflow(bit pop_in_write);
    int g0, o0;
    logic [7:0] b;
    g0 = got_q.size(); o0 = n_ovf;
    exp_q.delete(); e_ovf = 0;
    ev_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
      send_frame(b, 0, 0, 11, pop_in_write && (i == DEPTH));
      model_frame(b, 1, 1);
    end
    if (!pop_in_write) begin
      while (exp_q.size() > DEPTH) begin void'(exp_q.pop_back()); e_ovf++; end
    end
    @(negedge clk);
    n_cmp++;
    if (ev_count !== CW'(DEPTH)) begin n_err++; $display("FAIL ovf_count got %0d want %0d (pop=%0d)", ev_count, DEPTH, pop_in_write); end
    n_cmp++;
    if (n_ovf - o0 !== e_ovf) begin n_err++; $display("FAIL ovf_pulses got %0d want %0d (pop=%0d)", n_ovf - o0, e_ovf, pop_in_write); end
    tick(1);
    ev_ready = 1'b1;
    tick(DEPTH + 4);
    ev_ready = 1'b0;
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL ovf_events got %0d want %0d", got_q.size() - g0, exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[g0 + i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_order idx %0d got %h want %h", i, got_q[g0 + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    int g0, f0, p0;
    send_frame(8'hE0); model_frame(8'hE0, 1, 1);
    send_frame(8'($urandom), 0, 0, 6);
    reset = 1'b1;
    m_ext = 0; m_brk = 0;
    tick(2);
    @(negedge clk);
    n_cmp++;
    if ({ev_valid, ev_code, ev_ext, ev_break, ev_count, parity_err, frame_err, overflow} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs got %b want 0",
               {ev_valid, ev_code, ev_ext, ev_break, ev_count, parity_err, frame_err, overflow});
    end
    tick(1);
    reset = 1'b0;
    g0 = got_q.size(); f0 = n_ferr; p0 = n_perr;
    exp_q.delete();
    tick(TMO + 10);
    ev_ready = 1'b1;
    send_frame(8'h5A); model_frame(8'h5A, 1, 1);
    tick(10);
    n_cmp++;
    if (n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin n_err++; $display("FAIL midreset_err_pulses got %0d/%0d want 0/0", n_ferr - f0, n_perr - p0); end
    n_cmp++;
    if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL midreset_events got %0d want 1", got_q.size() - g0); end
    else begin
      n_cmp++;
      if (got_q[g0] !== exp_q[0]) begin n_err++; $display("FAIL midreset_event got %h want %h", got_q[g0], exp_q[0]); end
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_random_stream;
    int g0, f0, p0, o0, r;
    bit done;
    logic [7:0] b;
    bit bp, bs;
    g0 = got_q.size(); f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
    exp_q.delete(); e_ferr = 0; e_perr = 0;
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          r = $urandom_range(0, 9);
          b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
          r = $urandom_range(0, 9);
          bp = (r == 0);
          bs = (r == 1);
          send_frame(b, bp, bs);
          model_frame(b, !bp, !bs);
        end
        done = 1;
      end
      while (!done) begin
        ev_ready = ($urandom_range(0, 1) == 1);
        tick(1);
      end
    join
    ev_ready = 1'b1;
    tick(DEPTH + 4);
    ev_ready = 1'b0;
    n_cmp++;
    if (n_ferr - f0 !== e_ferr || n_perr - p0 !== e_perr) begin
      n_err++;
      $display("FAIL random_err_pulses got %0d/%0d want %0d/%0d", n_ferr - f0, n_perr - p0, e_ferr, e_perr);
    end
    n_cmp++;
    if (n_ovf - o0 !== 0) begin n_err++; $display("FAIL random_overflow got %0d want 0", n_ovf - o0); end
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL random_events got %0d want %0d", got_q.size() - g0, exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[g0 + i] !== exp_q[i]) begin n_err++; $display("FAIL random_event idx %0d got %h want %h", i, got_q[g0 + i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_prefix;
    test_parity;
    test_timeout(0);
    test_timeout(1);
    test_overflow(0);
    test_overflow(1);
    test_reset_midframe;
    test_random_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
